// File: rtl/srff_bank_driver_pkg.sv
// srff_drv_pkg: shared states, default parameters and S/R excitation codes for the SR bank driver.
package srff_drv_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;
    localparam int DEF_WIDTH         = 8;
    localparam int DEF_SETTLE_CYCLES = 1;
    localparam int DEF_MAX_RETRY     = 2;
    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] RST  = 2'b01;
    localparam logic [1:0] SET  = 2'b10;
endpackage

// File: rtl/srff_bank_driver_sr_excite.sv
// sr_excite: per-bit minimal SR excitation from current and desired Q; never yields S=R=1.
module sr_excite
    import srff_drv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] q_cur,
    input  logic [WIDTH-1:0] q_next,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign {s[i], r[i]} = (q_cur[i] == q_next[i]) ? HOLD : (q_next[i] ? SET : RST);
    end
endmodule

// File: rtl/srff_bank_driver.sv
// srff_bank_driver: writes a target word into an SR flip-flop bank via one-cycle S/R pulses,
// then reads Q back and retries up to MAX_RETRY times before flagging an error.
module srff_bank_driver
    import srff_drv_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [WIDTH-1:0] target,
    output logic             ready,
    output logic [WIDTH-1:0] s_out,
    output logic [WIDTH-1:0] r_out,
    input  logic [WIDTH-1:0] q_in,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] mismatch
);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t           state, state_n;
    logic [WIDTH-1:0] tgt_q, tgt_n, s_n, r_n, mm_n, ex_s, ex_r, diff;
    logic [RW-1:0]    retry, retry_n;
    logic [SW-1:0]    settle, settle_n;

    assign ready = state == IDLE;
    assign done  = state == DONE;
    assign err   = state == ERR;
    assign diff  = q_in ^ tgt_q;

    // On the accept edge tgt_q is not yet loaded, so excite straight from target.
    sr_excite #(.WIDTH(WIDTH)) u_excite (
        .q_cur (q_in),
        .q_next(ready ? target : tgt_q),
        .s     (ex_s),
        .r     (ex_r)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tgt_q    <= '0;
            s_out    <= '0;
            r_out    <= '0;
            mismatch <= '0;
            retry    <= '0;
            settle   <= '0;
        end else begin
            state    <= state_n;
            tgt_q    <= tgt_n;
            s_out    <= s_n;
            r_out    <= r_n;
            mismatch <= mm_n;
            retry    <= retry_n;
            settle   <= settle_n;
        end
    end

    always_comb begin
        state_n  = state;
        tgt_n    = tgt_q;
        s_n      = '0;
        r_n      = '0;
        mm_n     = mismatch;
        retry_n  = retry;
        settle_n = settle;
        case (state)
            IDLE: if (req) begin
                state_n = DRIVE;
                tgt_n   = target;
                retry_n = '0;
                s_n     = ex_s;
                r_n     = ex_r;
            end
            DRIVE: begin
                state_n  = SETTLE;
                settle_n = SW'(SETTLE_CYCLES - 1);
            end
            SETTLE: begin
                state_n  = (settle == '0) ? CHECK : SETTLE;
                settle_n = (settle == '0) ? settle : settle - SW'(1);
            end
            CHECK: begin
                mm_n = diff;
                if (diff == '0) state_n = DONE;
                else if (retry < RW'(MAX_RETRY)) begin
                    state_n = DRIVE;
                    retry_n = retry + RW'(1);
                    s_n     = ex_s;
                    r_n     = ex_r;
                end else state_n = ERR;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
